obstacle_timebase: RTL and testbench
====================================

// Module: obstacle_timebase
// PURPOSE
// - Timing and randomness source for the obstacle datapath, fully synchronous to clock.
// - Outputs a 1-clock "frame" tick every DELAY_CYCLES enabled clocks.
// - Outputs a 1-clock "next" step tick every FRAMES_PER_STEP frame ticks.
// - Outputs a free-running 5-bit pseudo-random value for obstacle x placement.
// PARAMETERS
// - DELAY_CYCLES     833333  enabled clocks per frame tick (60 Hz at 50 MHz); legal range >=2
// - FRAMES_PER_STEP  15      frame ticks per next tick; legal range >=1
// - LFSR_SEED        5'h01   LFSR reset value; must be nonzero
// PORTS
// - clock     in   1  system clock, rising edge
// - resetn    in   1  reset; synchronous, active-low
// - enable    in   1  delay-counter run enable (the draw request)
// - frame     out  1  registered pulse, high exactly 1 clock per frame period
// - next      out  1  registered pulse, high exactly 1 clock per step
// - rand_num  out  5  current LFSR state, never 0
// BEHAVIOUR
// - Reset (resetn=0 at a rising edge):
//   - dcount <= DELAY_CYCLES-1, frame <= 0
//   - fcount <= 0, next <= 0
//   - lfsr <= LFSR_SEED
//   - Reset dominates every other condition, including mid-count.
// - Delay counter (width $clog2(DELAY_CYCLES)):
//   - enable=1, dcount!=0: dcount decrements; frame <= 0.
//   - enable=1, dcount==0: dcount reloads to DELAY_CYCLES-1; frame <= 1.
//   - enable=0: dcount holds; frame <= 0. The count pauses and is not restarted.
//   - First frame pulse is visible after the DELAY_CYCLES-th enabled edge after reset.
// - Frame counter (width $clog2(FRAMES_PER_STEP)+1):
//   - Advances only in cycles where frame==1 (clock-enable, not a derived clock).
//   - frame=1, fcount==FRAMES_PER_STEP-1: fcount <= 0; next <= 1.
//   - frame=1, otherwise: fcount increments; next <= 0.
//   - frame=0: fcount holds; next <= 0.
//   - Latency: next is high the clock after the completing frame pulse.
//   - next never coincides with frame, because frame is never high on 2 consecutive clocks.
// - LFSR: Fibonacci form, polynomial x^5+x^3+1.
//   - Every clock (independent of enable): fb = q[4]^q[2]; q <= {q[3:0], fb}.
//   - Period 31 (maximal).
//   - Lock-up guard: if q==0, load LFSR_SEED on the next clock.
//   - rand_num = q, driven directly from the register.
// - All outputs are registers; no combinational path from inputs to outputs.
// STRUCTURE
// - Shared package obstacle_pkg:
//   - OBS_DELAY_CYCLES, OBS_FRAMES_PER_STEP
//   - OBS_LFSR_SEED, OBS_LFSR_TAPS (5'b10100)
// - One sub-module: obstacle_lfsr5 (clock, resetn, q[4:0]), holding the LFSR and lock-up guard.
// - Delay and frame counters are inline always blocks in the top module.
// TESTING
// - Use DELAY_CYCLES=4, FRAMES_PER_STEP=3 unless stated otherwise.
// - Reset: hold resetn=0 for 3 clocks -> frame=0, next=0, rand_num=5'h01.
// - enable held at 1 after reset:
//   - frame high after edges 4, 8, 12, each 1 clock wide.
//   - next high only after edge 13.
// - enable dropped for 5 clocks mid-period (after edge 2) -> frame delayed by exactly 5 clocks, to after edge 9.
// - LFSR from seed 01 -> rand_num 02, 04, 09, 12, 05 on successive clocks.
//   - Returns to 01 after 31 clocks; never 0 over 100 clocks.
// - Force LFSR state to 0 -> rand_num = 01 one clock later.
// - Assert resetn=0 for one edge while dcount=1 -> no frame pulse; counting restarts from DELAY_CYCLES-1.

Source files
------------

// File: rtl/obstacle_pkg.sv
`default_nettype none
// ============================================================================
// Module  : obstacle_pkg
// Purpose : Shared constants and helpers for the obstacle timebase block.
//           Holds the default frame/step timing and the 5-bit LFSR
//           seed and tap mask used by obstacle_lfsr5.
// Ports   : (package, no ports)
// Revision: 1.0  initial release
// ============================================================================
package obstacle_pkg;

  // 60 Hz frame tick from a 50 MHz clock.
  localparam int unsigned OBS_DELAY_CYCLES    = 833333;
  localparam int unsigned OBS_FRAMES_PER_STEP = 15;

  // x^5 + x^3 + 1: feedback taps are q[4] and q[2].
  localparam logic [4:0]  OBS_LFSR_SEED = 5'h01;
  localparam logic [4:0]  OBS_LFSR_TAPS = 5'b10100;

  function automatic logic lfsr_feedback(input logic [4:0] state);
    return ^(state & OBS_LFSR_TAPS);
  endfunction

endpackage
`default_nettype wire

// File: rtl/obstacle_lfsr5.sv
`default_nettype none
// ============================================================================
// Module  : obstacle_lfsr5
// Purpose : Free-running 5-bit Fibonacci LFSR (period 31) with a lock-up
//           guard that reloads the seed if the register is ever all-zero.
// Ports   : clock   in  1  system clock, rising edge
//           resetn  in  1  synchronous active-low reset
//           q       out 5  current LFSR state (registered, never 0)
// Revision: 1.0  initial release
// ============================================================================
module obstacle_lfsr5
  import obstacle_pkg::*;
#(
  parameter logic [4:0] SEED = OBS_LFSR_SEED
) (
  input  logic       clock,
  input  logic       resetn,
  output logic [4:0] q
);

  logic [4:0] state;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state <= SEED;
    end else if (state == 5'd0) begin
      // All-zero is a fixed point of the shift; escape it by reseeding.
      state <= SEED;
    end else begin
      state <= {state[3:0], lfsr_feedback(state)};
    end
  end

  assign q = state;

endmodule
`default_nettype wire

// File: rtl/obstacle_timebase.sv
`default_nettype none
// ============================================================================
// Module  : obstacle_timebase
// Purpose : Timing and randomness source for the obstacle datapath.
//           frame pulses once every DELAY_CYCLES enabled clocks, next
//           pulses once every FRAMES_PER_STEP frame pulses, and rand_num
//           exposes a free-running 5-bit LFSR.
// Ports   : clock     in  1  system clock, rising edge
//           resetn    in  1  synchronous active-low reset
//           enable    in  1  delay-counter run enable (draw request)
//           frame     out 1  registered 1-clock frame tick
//           next      out 1  registered 1-clock step tick
//           rand_num  out 5  LFSR state, never 0
// Revision: 1.0  initial release
// ============================================================================
module obstacle_timebase
  import obstacle_pkg::*;
#(
  parameter int unsigned DELAY_CYCLES    = OBS_DELAY_CYCLES,
  parameter int unsigned FRAMES_PER_STEP = OBS_FRAMES_PER_STEP,
  parameter logic [4:0]  LFSR_SEED       = OBS_LFSR_SEED
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       enable,
  output logic       frame,
  output logic       next,
  output logic [4:0] rand_num
);

  localparam int DW = $clog2(DELAY_CYCLES);
  localparam int FW = $clog2(FRAMES_PER_STEP) + 1;

  localparam logic [DW-1:0] DCOUNT_RELOAD = DW'(DELAY_CYCLES - 1);
  localparam logic [FW-1:0] FCOUNT_LAST   = FW'(FRAMES_PER_STEP - 1);

  logic [DW-1:0] dcount;
  logic [FW-1:0] fcount;

  // Delay counter: counts down only while enabled; a paused count resumes
  // where it left off rather than restarting.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      dcount <= DCOUNT_RELOAD;
      frame  <= 1'b0;
    end else if (enable) begin
      if (dcount == '0) begin
        dcount <= DCOUNT_RELOAD;
        frame  <= 1'b1;
      end else begin
        dcount <= dcount - DW'(1);
        frame  <= 1'b0;
      end
    end else begin
      frame <= 1'b0;
    end
  end

  // Frame counter: frame is used as a clock enable, so next lands one
  // clock after the completing frame pulse and never overlaps it.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      fcount <= '0;
      next   <= 1'b0;
    end else if (frame) begin
      if (fcount == FCOUNT_LAST) begin
        fcount <= '0;
        next   <= 1'b1;
      end else begin
        fcount <= fcount + FW'(1);
        next   <= 1'b0;
      end
    end else begin
      next <= 1'b0;
    end
  end

  obstacle_lfsr5 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clock  (clock),
    .resetn (resetn),
    .q      (rand_num)
  );

endmodule
`default_nettype wire

// File: tb/tb_obstacle_timebase.sv
`default_nettype none
// ============================================================================
// Module  : tb_obstacle_timebase
// Purpose : Directed self-checking bench for obstacle_timebase with
//           DELAY_CYCLES=4, FRAMES_PER_STEP=3, seed 5'h01.
// Ports   : (none)
// Revision: 1.0  initial release
// ============================================================================
module tb_obstacle_timebase;

  logic       clock;
  logic       resetn;
  logic       enable;
  logic       frame;
  logic       next;
  logic [4:0] rand_num;

  int total;
  int bad;

  logic [4:0] lfsr_head [5];

  obstacle_timebase #(
    .DELAY_CYCLES    (4),
    .FRAMES_PER_STEP (3),
    .LFSR_SEED       (5'h01)
  ) dut (
    .clock    (clock),
    .resetn   (resetn),
    .enable   (enable),
    .frame    (frame),
    .next     (next),
    .rand_num (rand_num)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // Advance past one rising edge and sample away from it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset();
    resetn = 1'b0;
    enable = 1'b0;
    repeat (3) tick();
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    enable = 1'b1;
    repeat (3) tick();
    total++;
    if (frame !== 1'b0) begin
      bad++;
      $display("FAIL reset_frame: got %b want 0", frame);
    end
    total++;
    if (next !== 1'b0) begin
      bad++;
      $display("FAIL reset_next: got %b want 0", next);
    end
    total++;
    if (rand_num !== 5'h01) begin
      bad++;
      $display("FAIL reset_rand: got %h want 01", rand_num);
    end
    resetn = 1'b1;
    enable = 1'b0;
  endtask

  // enable held high: frame after edges 4, 8, 12; next after edge 13 only.
  task automatic test_frame_step();
    logic exp_frame;
    logic exp_next;
    apply_reset();
    enable = 1'b1;
    for (int e = 1; e <= 16; e++) begin
      tick();
      exp_frame = (e == 4) || (e == 8) || (e == 12) || (e == 16);
      exp_next  = (e == 13);
      total++;
      if (frame !== exp_frame) begin
        bad++;
        $display("FAIL frame_edge%0d: got %b want %b", e, frame, exp_frame);
      end
      total++;
      if (next !== exp_next) begin
        bad++;
        $display("FAIL next_edge%0d: got %b want %b", e, next, exp_next);
      end
    end
    enable = 1'b0;
  endtask

  // enable dropped for 5 clocks after edge 2: frame moves to edge 9.
  task automatic test_enable_pause();
    logic exp_frame;
    apply_reset();
    enable = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      if (e == 3) enable = 1'b0;
      if (e == 8) enable = 1'b1;
      tick();
      exp_frame = (e == 9);
      total++;
      if (frame !== exp_frame) begin
        bad++;
        $display("FAIL pause_frame_edge%0d: got %b want %b", e, frame, exp_frame);
      end
    end
    enable = 1'b0;
  endtask

  task automatic test_lfsr();
    logic seen_zero;
    seen_zero = 1'b0;
    apply_reset();
    for (int i = 1; i <= 100; i++) begin
      tick();
      if (rand_num == 5'd0) seen_zero = 1'b1;
      if (i <= 5) begin
        total++;
        if (rand_num !== lfsr_head[i-1]) begin
          bad++;
          $display("FAIL lfsr_step%0d: got %h want %h", i, rand_num, lfsr_head[i-1]);
        end
      end else if (i < 31) begin
        total++;
        if (rand_num === 5'h01) begin
          bad++;
          $display("FAIL lfsr_early_repeat_step%0d: got %h want not 01", i, rand_num);
        end
      end else if (i == 31) begin
        total++;
        if (rand_num !== 5'h01) begin
          bad++;
          $display("FAIL lfsr_period: got %h want 01", rand_num);
        end
      end
    end
    total++;
    if (seen_zero !== 1'b0) begin
      bad++;
      $display("FAIL lfsr_nonzero: saw zero=%b want 0", seen_zero);
    end
  endtask

  task automatic test_lockup();
    @(negedge clock);
    force dut.u_lfsr.state = 5'd0;
    #1;
    release dut.u_lfsr.state;
    tick();
    total++;
    if (rand_num !== 5'h01) begin
      bad++;
      $display("FAIL lfsr_lockup: got %h want 01", rand_num);
    end
  endtask

  // Reset while dcount==1: no frame, and the full 4-edge count restarts.
  task automatic test_reset_midcount();
    logic exp_frame;
    apply_reset();
    enable = 1'b1;
    repeat (2) tick();
    resetn = 1'b0;
    tick();
    total++;
    if (frame !== 1'b0) begin
      bad++;
      $display("FAIL midreset_frame: got %b want 0", frame);
    end
    resetn = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      tick();
      exp_frame = (e == 4);
      total++;
      if (frame !== exp_frame) begin
        bad++;
        $display("FAIL midreset_frame_edge%0d: got %b want %b", e, frame, exp_frame);
      end
    end
    total++;
    if (next !== 1'b0) begin
      bad++;
      $display("FAIL midreset_next: got %b want 0", next);
    end
    enable = 1'b0;
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    resetn = 1'b0;
    enable = 1'b0;
    lfsr_head[0] = 5'h02;
    lfsr_head[1] = 5'h04;
    lfsr_head[2] = 5'h09;
    lfsr_head[3] = 5'h12;
    lfsr_head[4] = 5'h05;

    test_reset();
    test_frame_step();
    test_enable_pause();
    test_lfsr();
    test_lockup();
    test_reset_midcount();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
